// File: rtl/slave_rd_resp_fmt_if.sv
// Bundle of the command, memory read-beat and AXI R-channel signals around slave_rd_resp_fmt.
// The slave modport is the formatter's view; master is the driving environment.
interface slave_rd_resp_fmt_if #(
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 512
);
    logic                  cmd_vld;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  cmd_ready;
    logic                  mem2slave_rdresp_vld;
    logic [DATA_WIDTH-1:0] mem2slave_rdresp_data;
    logic                  rdresp_data_ready;
    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  err_overflow;
    logic                  err_orphan;

    modport slave (
        input  cmd_vld, cmd_id, cmd_len, mem2slave_rdresp_vld, mem2slave_rdresp_data, rready,
        output cmd_ready, rdresp_data_ready, rvalid, rid, rdata, rresp, rlast,
               err_overflow, err_orphan
    );

    modport master (
        output cmd_vld, cmd_id, cmd_len, mem2slave_rdresp_vld, mem2slave_rdresp_data, rready,
        input  cmd_ready, rdresp_data_ready, rvalid, rid, rdata, rresp, rlast,
               err_overflow, err_orphan
    );
endinterface

// File: rtl/slave_rd_resp_fmt.sv
// Formats raw memory read beats plus accepted AR commands into an AXI R channel,
// buffering beats under RREADY backpressure and throttling the memory stage.
module slave_rd_resp_fmt #(
    parameter int          AXI_SLAVE_ID = 0,
    parameter int unsigned ID_WIDTH     = 8,
    parameter int unsigned LEN_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned CMD_DEPTH    = 8,
    parameter int unsigned DATA_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    slave_rd_resp_fmt_if.slave    bus
);
    localparam int unsigned CPW = $clog2(CMD_DEPTH);
    localparam int unsigned CCW = CPW + 1;
    localparam int unsigned DPW = $clog2(DATA_DEPTH);
    localparam int unsigned DCW = DPW + 1;

    // Reject unusable FIFO geometries at elaboration time.
    if (AXI_SLAVE_ID < 0 || CMD_DEPTH < 2 || DATA_DEPTH < 4) begin : g_bad_cfg
        $error("slave_rd_resp_fmt[%0d]: unsupported FIFO depth configuration", AXI_SLAVE_ID);
    end

    logic [ID_WIDTH-1:0]   r_cmd_id_mem  [CMD_DEPTH];
    logic [LEN_WIDTH-1:0]  r_cmd_len_mem [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem    [DATA_DEPTH];

    logic [CPW-1:0]        r_cmd_wr;
    logic [CPW-1:0]        r_cmd_rd;
    logic [CCW-1:0]        r_cmd_cnt;
    logic [DPW-1:0]        r_data_wr;
    logic [DPW-1:0]        r_data_rd;
    logic [DCW-1:0]        r_data_cnt;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;

    logic                  r_rvalid;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rlast;
    logic                  r_err_overflow;
    logic                  r_err_orphan;

    logic w_cmd_full;
    logic w_data_full;
    logic w_load;
    logic w_head_last;
    logic w_cmd_push;
    logic w_cmd_pop;
    logic w_data_push;
    logic w_cmd_drop;
    logic w_data_drop;
    logic w_orphan;

    assign w_cmd_full  = (r_cmd_cnt == CCW'(CMD_DEPTH));
    assign w_data_full = (r_data_cnt == DCW'(DATA_DEPTH));
    assign w_load      = (r_data_cnt != '0) && (r_cmd_cnt != '0) && (!r_rvalid || bus.rready);
    assign w_head_last = (r_beat_cnt == r_cmd_len_mem[r_cmd_rd]);
    assign w_cmd_pop   = w_load && w_head_last;
    assign w_cmd_push  = bus.cmd_vld && !w_cmd_full;
    assign w_cmd_drop  = bus.cmd_vld && w_cmd_full;
    // A full data FIFO still accepts a beat when the output register drains one this cycle.
    assign w_data_push = bus.mem2slave_rdresp_vld && (!w_data_full || w_load);
    assign w_data_drop = bus.mem2slave_rdresp_vld && w_data_full && !w_load;
    assign w_orphan    = bus.mem2slave_rdresp_vld && (r_cmd_cnt == '0);

    assign bus.cmd_ready         = !w_cmd_full;
    // Counts the beat already in flight; a same-cycle pop is deliberately not credited.
    assign bus.rdresp_data_ready = (r_data_cnt + DCW'(bus.mem2slave_rdresp_vld)) < DCW'(DATA_DEPTH);
    assign bus.rvalid            = r_rvalid;
    assign bus.rid               = r_rid;
    assign bus.rdata             = r_rdata;
    assign bus.rresp             = 2'b00;
    assign bus.rlast             = r_rlast;
    assign bus.err_overflow      = r_err_overflow;
    assign bus.err_orphan        = r_err_orphan;

    // FIFO storage; contents need no reset since the counts gate every read.
    always_ff @(posedge clk) begin
        if (w_cmd_push) begin
            r_cmd_id_mem[r_cmd_wr]  <= bus.cmd_id;
            r_cmd_len_mem[r_cmd_wr] <= bus.cmd_len;
        end
        if (w_data_push) begin
            r_data_mem[r_data_wr] <= bus.mem2slave_rdresp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_wr       <= '0;
            r_cmd_rd       <= '0;
            r_cmd_cnt      <= '0;
            r_data_wr      <= '0;
            r_data_rd      <= '0;
            r_data_cnt     <= '0;
            r_beat_cnt     <= '0;
            r_rvalid       <= 1'b0;
            r_rid          <= '0;
            r_rdata        <= '0;
            r_rlast        <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_orphan   <= 1'b0;
        end else begin
            if (w_cmd_push) begin
                r_cmd_wr <= r_cmd_wr + CPW'(1);
            end
            if (w_cmd_pop) begin
                r_cmd_rd <= r_cmd_rd + CPW'(1);
            end
            r_cmd_cnt <= r_cmd_cnt + CCW'(w_cmd_push) - CCW'(w_cmd_pop);

            if (w_data_push) begin
                r_data_wr <= r_data_wr + DPW'(1);
            end
            if (w_load) begin
                r_data_rd <= r_data_rd + DPW'(1);
            end
            r_data_cnt <= r_data_cnt + DCW'(w_data_push) - DCW'(w_load);

            // Output register only advances when empty or its current beat is being taken.
            if (w_load) begin
                r_rvalid   <= 1'b1;
                r_rdata    <= r_data_mem[r_data_rd];
                r_rid      <= r_cmd_id_mem[r_cmd_rd];
                r_rlast    <= w_head_last;
                r_beat_cnt <= w_head_last ? '0 : r_beat_cnt + LEN_WIDTH'(1);
            end else if (r_rvalid && bus.rready) begin
                r_rvalid <= 1'b0;
            end

            if (w_cmd_drop || w_data_drop) begin
                r_err_overflow <= 1'b1;
            end
            if (w_orphan) begin
                r_err_orphan <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_slave_rd_resp_fmt.sv
// Directed bench for slave_rd_resp_fmt: a per-cycle vector table for the basic burst plus
// hand-written sequences for backpressure, long bursts, overflow, orphans and reset.
module tb_slave_rd_resp_fmt;
    localparam int unsigned IW = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned DW = 512;

    logic clk;
    logic reset;

    slave_rd_resp_fmt_if #(.ID_WIDTH(IW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) bus();

    slave_rd_resp_fmt #(
        .AXI_SLAVE_ID(0), .ID_WIDTH(IW), .LEN_WIDTH(LW), .DATA_WIDTH(DW),
        .CMD_DEPTH(8), .DATA_DEPTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          cv;
        logic [7:0]  cid;
        logic [7:0]  clen;
        bit          dv;
        logic [DW-1:0] data;
        bit          rr;
        bit          e_rvalid;
        logic [7:0]  e_rid;
        logic [DW-1:0] e_data;
        bit          e_rlast;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_id[$];
    int         q_dk[$];
    bit         q_last[$];

    function automatic logic [DW-1:0] mk(input int k);
        mk = {16{32'(k) + 32'hC0DE_0000}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_vld               = 1'b0;
        bus.cmd_id                = '0;
        bus.cmd_len               = '0;
        bus.mem2slave_rdresp_vld  = 1'b0;
        bus.mem2slave_rdresp_data = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rvalid"},  DW'(bus.rvalid), DW'(1'b0));
        chk({tag, " rid"},     DW'(bus.rid), DW'(0));
        chk({tag, " rdata"},   bus.rdata, '0);
        chk({tag, " rresp"},   DW'(bus.rresp), DW'(0));
        chk({tag, " rlast"},   DW'(bus.rlast), DW'(1'b0));
        chk({tag, " cmd_ready"}, DW'(bus.cmd_ready), DW'(1'b1));
        chk({tag, " data_ready"}, DW'(bus.rdresp_data_ready), DW'(1'b1));
        chk({tag, " err_overflow"}, DW'(bus.err_overflow), DW'(1'b0));
        chk({tag, " err_orphan"}, DW'(bus.err_orphan), DW'(1'b0));
    endtask

    task automatic push_cmd(input logic [7:0] id, input logic [7:0] len);
        @(negedge clk);
        bus.cmd_vld = 1'b1;
        bus.cmd_id  = id;
        bus.cmd_len = len;
        @(posedge clk);
        #1;
        bus.cmd_vld = 1'b0;
    endtask

    task automatic push_beat(input int k);
        @(negedge clk);
        bus.mem2slave_rdresp_vld  = 1'b1;
        bus.mem2slave_rdresp_data = mk(k);
        @(posedge clk);
        #1;
        bus.mem2slave_rdresp_vld  = 1'b0;
    endtask

    task automatic expect_beat(input logic [7:0] id, input int dk, input bit last);
        q_id.push_back(id);
        q_dk.push_back(dk);
        q_last.push_back(last);
    endtask

    // Holds RREADY high and checks each beat seen at a falling edge against the expected queue.
    task automatic collect(input string tag, input int n, input int budget);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        @(negedge clk);
        bus.rready = 1'b1;
        while (got < n && cyc < budget) begin
            if (bus.rvalid) begin
                chk($sformatf("%s beat%0d rid", tag, got), DW'(bus.rid), DW'(q_id.pop_front()));
                chk($sformatf("%s beat%0d rdata", tag, got), bus.rdata, mk(q_dk.pop_front()));
                chk($sformatf("%s beat%0d rlast", tag, got), DW'(bus.rlast), DW'(q_last.pop_front()));
                chk($sformatf("%s beat%0d rresp", tag, got), DW'(bus.rresp), DW'(0));
                got++;
            end
            if (got < n) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (got < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got %0d beats expected %0d", tag, got, n);
            q_id.delete();
            q_dk.delete();
            q_last.delete();
        end
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int   g;

        vt[0] = '{1, 8'h3, 8'h3, 0, '0,    1, 0, 8'h0, '0,    0};
        vt[1] = '{0, 8'h0, 8'h0, 1, mk(0), 1, 0, 8'h0, '0,    0};
        vt[2] = '{0, 8'h0, 8'h0, 1, mk(1), 1, 1, 8'h3, mk(0), 0};
        vt[3] = '{0, 8'h0, 8'h0, 1, mk(2), 1, 1, 8'h3, mk(1), 0};
        vt[4] = '{0, 8'h0, 8'h0, 1, mk(3), 1, 1, 8'h3, mk(2), 0};
        vt[5] = '{0, 8'h0, 8'h0, 0, '0,    1, 1, 8'h3, mk(3), 1};
        vt[6] = '{0, 8'h0, 8'h0, 0, '0,    1, 0, 8'h3, mk(3), 1};

        reset = 1'b0;
        idle_inputs();
        bus.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        reset = 1'b1;

        // Basic 4-beat burst, one vector per clock.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.cmd_vld               = vt[i].cv;
            bus.cmd_id                = vt[i].cid;
            bus.cmd_len               = vt[i].clen;
            bus.mem2slave_rdresp_vld  = vt[i].dv;
            bus.mem2slave_rdresp_data = vt[i].data;
            bus.rready                = vt[i].rr;
            @(posedge clk);
            #1;
            chk($sformatf("t1 v%0d rvalid", i), DW'(bus.rvalid), DW'(vt[i].e_rvalid));
            chk($sformatf("t1 v%0d rid", i), DW'(bus.rid), DW'(vt[i].e_rid));
            chk($sformatf("t1 v%0d rdata", i), bus.rdata, vt[i].e_data);
            chk($sformatf("t1 v%0d rlast", i), DW'(bus.rlast), DW'(vt[i].e_rlast));
            chk($sformatf("t1 v%0d rresp", i), DW'(bus.rresp), DW'(0));
            chk($sformatf("t1 v%0d cmd_ready", i), DW'(bus.cmd_ready), DW'(1'b1));
        end
        idle_inputs();
        bus.rready = 1'b0;
        chk("t1 err_overflow", DW'(bus.err_overflow), DW'(1'b0));
        chk("t1 err_orphan", DW'(bus.err_orphan), DW'(1'b0));

        // Backpressure: 17 beats with RREADY low; head held, ready drops at the 16th slot.
        push_cmd(8'h3, 8'd3);
        push_cmd(8'h4, 8'd12);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            bus.mem2slave_rdresp_vld  = 1'b1;
            bus.mem2slave_rdresp_data = mk(100 + k);
            #1;
            if (k == 15) chk("t2 ready k15", DW'(bus.rdresp_data_ready), DW'(1'b1));
            if (k == 16) chk("t2 ready k16", DW'(bus.rdresp_data_ready), DW'(1'b0));
            @(posedge clk);
            #1;
            if (k >= 1) begin
                chk($sformatf("t2 hold%0d rvalid", k), DW'(bus.rvalid), DW'(1'b1));
                chk($sformatf("t2 hold%0d rdata", k), bus.rdata, mk(100));
                chk($sformatf("t2 hold%0d rid", k), DW'(bus.rid), DW'(8'h3));
            end
            expect_beat((k < 4) ? 8'h3 : 8'h4, 100 + k, (k == 3) || (k == 16));
        end
        @(negedge clk);
        bus.mem2slave_rdresp_vld = 1'b0;
        #1;
        chk("t2 ready full", DW'(bus.rdresp_data_ready), DW'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        chk("t2 late rdata", bus.rdata, mk(100));
        collect("t2", 17, 200);
        chk("t2 err_overflow", DW'(bus.err_overflow), DW'(1'b0));

        // Back-to-back single-beat and 256-beat bursts with flow-controlled beat source.
        push_cmd(8'h1, 8'd0);
        push_cmd(8'h2, 8'd255);
        expect_beat(8'h1, 2000, 1'b1);
        for (int k = 1; k < 257; k++) expect_beat(8'h2, 2000 + k, k == 256);
        fork
            begin
                for (int k = 0; k < 257; k++) begin
                    @(negedge clk);
                    bus.mem2slave_rdresp_vld = 1'b0;
                    #1;
                    g = 0;
                    while (!bus.rdresp_data_ready && g < 100) begin
                        @(negedge clk);
                        #1;
                        g++;
                    end
                    bus.mem2slave_rdresp_vld  = 1'b1;
                    bus.mem2slave_rdresp_data = mk(2000 + k);
                end
                @(negedge clk);
                bus.mem2slave_rdresp_vld = 1'b0;
            end
            collect("t3", 257, 3000);
        join
        chk("t3 err_overflow", DW'(bus.err_overflow), DW'(1'b0));
        chk("t3 err_orphan", DW'(bus.err_orphan), DW'(1'b0));

        // Command FIFO overflow: ninth command is dropped.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.cmd_vld = 1'b1;
            bus.cmd_id  = 8'(8 + i);
            bus.cmd_len = 8'd0;
            @(posedge clk);
            #1;
            chk($sformatf("t4 cmd%0d cmd_ready", i), DW'(bus.cmd_ready), DW'(i < 7));
            chk($sformatf("t4 cmd%0d err_overflow", i), DW'(bus.err_overflow), DW'(i == 8));
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset("t4 reset");
        @(negedge clk);
        reset = 1'b1;

        // Orphan beat is flagged, then paired with a late command.
        push_beat(500);
        chk("t5 err_orphan", DW'(bus.err_orphan), DW'(1'b1));
        chk("t5 rvalid0", DW'(bus.rvalid), DW'(1'b0));
        @(posedge clk);
        #1;
        chk("t5 rvalid1", DW'(bus.rvalid), DW'(1'b0));
        push_cmd(8'h5, 8'd0);
        chk("t5 rvalid2", DW'(bus.rvalid), DW'(1'b0));
        @(posedge clk);
        #1;
        chk("t5 rvalid3", DW'(bus.rvalid), DW'(1'b1));
        expect_beat(8'h5, 500, 1'b1);
        collect("t5", 1, 20);
        chk("t5 err_overflow", DW'(bus.err_overflow), DW'(1'b0));

        // Reset in the middle of a burst, then a fresh burst.
        bus.rready = 1'b1;
        push_cmd(8'h6, 8'd3);
        for (int k = 0; k < 4; k++) push_beat(600 + k);
        chk("t6 pre rdata", bus.rdata, mk(602));
        chk("t6 pre rvalid", DW'(bus.rvalid), DW'(1'b1));
        @(negedge clk);
        reset = 1'b0;
        bus.rready = 1'b0;
        #1;
        chk_reset("t6 reset");
        @(posedge clk);
        #1;
        chk("t6 post rvalid", DW'(bus.rvalid), DW'(1'b0));
        @(negedge clk);
        reset = 1'b1;
        push_cmd(8'h7, 8'd1);
        push_beat(700);
        push_beat(701);
        expect_beat(8'h7, 700, 1'b0);
        expect_beat(8'h7, 701, 1'b1);
        collect("t6", 2, 20);
        @(posedge clk);
        #1;
        chk("t6 end rvalid", DW'(bus.rvalid), DW'(1'b0));
        chk("t6 end err_overflow", DW'(bus.err_overflow), DW'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
